// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, FSM states, lane mask.
package rv32i_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Little-endian byte-lane mask for an access of the given size at addr[1:0].
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (funct3)
      F3_B, F3_BU: mask = 4'b0001 << addr_lo;
      F3_H, F3_HU: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables, store data replication, load shift/extend.
module dmem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  store_be_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  assign store_be_o = lane_mask(funct3_i, addr_lo_i);

  // Replicate right-aligned store data across all lanes; the byte enables pick the lane.
  always_comb begin
    store_data_o = store_data_i;
    case (funct3_i[1:0])
      2'b00:   store_data_o = {4{store_data_i[7:0]}};
      2'b01:   store_data_o = {2{store_data_i[15:0]}};
      default: store_data_o = store_data_i;
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by size.
  always_comb begin
    logic [31:0] shifted;
    shifted     = load_word_i >> {addr_lo_i, 3'b000};
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_o = {24'h0, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_o = {16'h0, shifted[15:0]};
      F3_W:    load_data_o = shifted;
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_wait.sv
// RV32I data memory with byte/half/word access, programmable wait states and error flags.
module data_memory_wait
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        misaligned,
  output logic        access_fault
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0]  LastCnt = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q, mis_q, fault_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic            accept, enter_resp;
  logic [31:0]     cur_addr, cur_wdata, store_data, load_data;
  logic [2:0]      cur_f3;
  logic            cur_we, cur_legal, cur_mis, cur_fault, cur_err;
  logic [IdxW-1:0] cur_idx;
  logic [3:0]      store_be;

  assign accept = req && (state_q == IDLE || state_q == RESP);

  // With zero wait states the RAM access happens on the accept edge, so use live inputs.
  assign cur_addr  = accept ? address    : addr_q;
  assign cur_wdata = accept ? write_data : wdata_q;
  assign cur_f3    = accept ? funct3     : f3_q;
  assign cur_we    = accept ? we         : we_q;
  assign cur_idx   = cur_addr[IdxW+1:2];

  // Legal funct3 codes differ between loads and stores.
  always_comb begin
    cur_legal = 1'b0;
    case (cur_f3)
      F3_B, F3_H, F3_W: cur_legal = 1'b1;
      F3_BU, F3_HU:     cur_legal = !cur_we;
      default:          cur_legal = 1'b0;
    endcase
  end

  assign cur_fault = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) || !cur_legal;
  assign cur_mis   = ((cur_f3 == F3_H || cur_f3 == F3_HU) && cur_addr[0]) ||
                     ((cur_f3 == F3_W) && (cur_addr[1:0] != 2'b00));
  assign cur_err   = cur_fault || cur_mis;

  dmem_lane_align u_align (
    .funct3_i     (cur_f3),
    .addr_lo_i    (cur_addr[1:0]),
    .store_data_i (cur_wdata),
    .load_word_i  (mem_q[cur_idx]),
    .store_be_o   (store_be),
    .store_data_o (store_data),
    .load_data_o  (load_data)
  );

  // Next-state logic: accept in IDLE/RESP, count wait states, then respond.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d = '0;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LastCnt) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= write_data;
        f3_q    <= funct3;
        we_q    <= we;
      end
      if (enter_resp) begin
        rdata_q <= (cur_err || cur_we) ? 32'h0 : load_data;
        mis_q   <= cur_mis;
        fault_q <= cur_fault;
      end
    end
  end

  // Store commit on the edge entering RESP; erroneous or reset-aborted stores never write.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) mem_q[cur_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  assign ready        = (state_q == RESP);
  assign read_data    = rdata_q;
  assign misaligned   = ready && mis_q;
  assign access_fault = ready && fault_q;

endmodule

// File: tb/tb_data_memory_wait.sv
// Scoreboard bench: one DUT with LATENCY=0, one with LATENCY=3, checked against a byte-array model.
module tb_data_memory_wait;

  localparam int unsigned Depth    = 256;
  localparam int unsigned WinBytes = 128;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    bit          chk_rd;
    logic        mis;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [2:0]  f3    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        mis   [2];
  logic        flt   [2];

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mm [2][WinBytes];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_wait #(.DEPTH_WORDS(Depth), .LATENCY(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .funct3(f3[0]), .address(addr[0]),
    .write_data(wdata[0]), .read_data(rdata[0]), .ready(rdy[0]), .misaligned(mis[0]),
    .access_fault(flt[0])
  );

  data_memory_wait #(.DEPTH_WORDS(Depth), .LATENCY(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .funct3(f3[1]), .address(addr[1]),
    .write_data(wdata[1]), .read_data(rdata[1]), .ready(rdy[1]), .misaligned(mis[1]),
    .access_fault(flt[1])
  );

  function automatic int unsigned lat(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain byte array, little-endian, applied in request order.
  task automatic model(input int d, input op_t o, output exp_t e);
    int unsigned n;
    bit          legal;
    logic [31:0] v;
    legal   = o.we ? (o.f3 inside {3'd0, 3'd1, 3'd2})
                   : (o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.fault = ((o.addr >> 2) >= Depth) || !legal;
    e.mis   = ((o.f3 == 3'd1 || o.f3 == 3'd5) && (o.addr % 2 != 0)) ||
              (o.f3 == 3'd2 && (o.addr % 4 != 0));
    e.rdata  = 32'h0;
    e.chk_rd = !o.we || e.fault || e.mis;
    e.cyc    = 0;
    n = 1 << o.f3[1:0];
    if (!e.fault && !e.mis) begin
      if (o.we) begin
        for (int k = 0; k < int'(n); k++) mm[d][o.addr + k] = o.wdata[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < int'(n); k++) v = v | (32'(mm[d][o.addr + k]) << (8 * k));
        if (!o.f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!o.f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
  endtask

  function automatic op_t mk(input bit w, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] wd);
    op_t o;
    o.we = w; o.f3 = f; o.addr = a; o.wdata = wd;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t         o;
    int unsigned r;
    int unsigned sz;
    r       = $urandom_range(0, 99);
    o.we    = 1'($urandom_range(0, 1));
    o.wdata = $urandom;
    if (r < 6) begin
      if (o.we) o.f3 = 3'($urandom_range(3, 7));
      else begin
        sz   = $urandom_range(0, 2);
        o.f3 = (sz == 0) ? 3'd3 : (sz == 1) ? 3'd6 : 3'd7;
      end
      o.addr = 32'($urandom_range(0, WinBytes / 4 - 1)) * 4;
    end else begin
      if (o.we) o.f3 = 3'($urandom_range(0, 2));
      else begin
        sz   = $urandom_range(0, 4);
        o.f3 = (sz < 3) ? 3'(sz) : 3'(sz + 1);
      end
      if (r < 12) begin
        o.f3   = 3'd2;
        o.addr = (Depth * 4) + 32'($urandom_range(0, 4095)) * 4;
      end else begin
        o.addr = 32'($urandom_range(0, WinBytes - 1));
        sz     = 1 << o.f3[1:0];
        if (r < 85) o.addr = o.addr & ~(32'(sz) - 1);
      end
    end
    return o;
  endfunction

  // Drive one request cycle; tracked requests go through the model and into the scoreboard.
  task automatic issue(input int d, input op_t o, input bit track);
    exp_t e;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = o.we; f3[d] = o.f3; addr[d] = o.addr; wdata[d] = o.wdata;
    if (track) begin
      model(d, o, e);
      e.cyc = cyc + 1 + lat(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Cycle with arbitrary inputs; r selects whether req is raised.
  task automatic junk(input int d, input bit r);
    @(posedge clk); #1;
    req[d] = r; we[d] = 1'($urandom_range(0, 1)); f3[d] = 3'($urandom_range(0, 7));
    addr[d] = $urandom; wdata[d] = $urandom;
  endtask

  task automatic issue3(input op_t o, input bit track);
    issue(1, o, track);
    for (int k = 0; k < 3; k++) junk(1, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  task automatic mon(input int d);
    exp_t e;
    bit   empty;
    if (rdy[d] === 1'b1) begin
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) chk($sformatf("unexpected_ready%0d", d), 32'h1, 32'h0);
      else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("ready_cycle%0d", d), cyc, e.cyc);
        if (e.chk_rd) chk($sformatf("read_data%0d", d), rdata[d], e.rdata);
        chk($sformatf("misaligned%0d", d), 32'(mis[d]), 32'(e.mis));
        chk($sformatf("access_fault%0d", d), 32'(flt[d]), 32'(e.fault));
      end
    end else begin
      chk($sformatf("flags_idle%0d", d), {30'h0, mis[d], flt[d]}, 32'h0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents ready.
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    op_t o;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; f3[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'h0);
      chk("reset_rdata", rdata[d], 32'h0);
      chk("reset_flags", {30'h0, mis[d], flt[d]}, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1; rst[0] = 1'b0; rst[1] = 1'b0;

    // Initialise the test window of both memories so every load has a known value.
    for (int w = 0; w < int'(WinBytes / 4); w++) issue(0, mk(1, 3'd2, 32'(w * 4), $urandom), 1);
    junk(0, 0);
    for (int w = 0; w < int'(WinBytes / 4); w++) issue3(mk(1, 3'd2, 32'(w * 4), $urandom), 1);
    junk(1, 0);
    drain();

    // Directed back-to-back sequence on the zero-wait instance.
    issue(0, mk(1, 3'd2, 32'h10, 32'hDEAD_BEEF), 1);
    issue(0, mk(0, 3'd2, 32'h10, 32'h0), 1);
    issue(0, mk(1, 3'd0, 32'h13, 32'h0000_0080), 1);
    issue(0, mk(0, 3'd0, 32'h13, 32'h0), 1);
    issue(0, mk(0, 3'd4, 32'h13, 32'h0), 1);
    issue(0, mk(0, 3'd2, 32'h10, 32'h0), 1);
    issue(0, mk(1, 3'd1, 32'h22, 32'h0000_8001), 1);
    issue(0, mk(0, 3'd1, 32'h22, 32'h0), 1);
    issue(0, mk(0, 3'd5, 32'h22, 32'h0), 1);
    issue(0, mk(1, 3'd1, 32'h21, 32'h0000_5A5A), 1);
    issue(0, mk(0, 3'd2, 32'h20, 32'h0), 1);
    issue(0, mk(0, 3'd2, Depth * 4, 32'h0), 1);
    issue(0, mk(1, 3'd3, 32'h30, 32'hCAFE_F00D), 1);
    issue(0, mk(0, 3'd2, 32'h30, 32'h0), 1);
    junk(0, 0);
    drain();

    // Random traffic, mostly back-to-back with occasional gaps.
    for (int i = 0; i < 300; i++) begin
      issue(0, rand_op(), 1);
      if ($urandom_range(0, 7) == 0) junk(0, 0);
    end
    junk(0, 0);
    drain();

    // Wait-state instance: latency, ignored mid-wait requests, input changes after accept.
    issue3(mk(0, 3'd2, 32'h0, 32'h0), 1);
    junk(1, 0);
    for (int i = 0; i < 120; i++) begin
      issue3(rand_op(), 1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) junk(1, 0);
    end
    junk(1, 0);
    drain();

    // Reset during WAIT discards the pending store and suppresses ready.
    issue(1, mk(1, 3'd2, 32'h40, 32'h1234_5678), 0);
    junk(1, 0);
    rst[1] = 1'b1;
    #1;
    chk("abort_ready", 32'(rdy[1]), 32'h0);
    repeat (2) @(posedge clk);
    #1; rst[1] = 1'b0;
    repeat (6) junk(1, 0);
    issue3(mk(0, 3'd2, 32'h40, 32'h0), 1);
    junk(1, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
